// File: rtl/keyprt_seq_player_if.sv
// Bus bundle for keyprt_seq_player: script programming, playback control,
// the PORT_KEYPRT command/response pair and the pass/fail status.
interface keyprt_seq_player_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              prgWe;
    logic [AW-1:0]     prgAddr;
    logic [39:0]       prgWdata;
    logic              start;
    logic              abort;
    logic [31:0]       keyprtCmd;
    logic [31:0]       keyprtRes;
    logic              busy;
    logic              done;
    logic              pass;
    logic [AW-1:0]     failStep;
    logic [31:0]       failData;
    logic [7:0]        errCount;

    modport master (
        output prgWe, prgAddr, prgWdata, start, abort, keyprtRes,
        input  keyprtCmd, busy, done, pass, failStep, failData, errCount
    );

    modport slave (
        input  prgWe, prgAddr, prgWdata, start, abort, keyprtRes,
        output keyprtCmd, busy, done, pass, failStep, failData, errCount
    );
endinterface

// File: rtl/keyprt_seq_player.sv
// Scripted key/pop/idle player for PORT_KEYPRT_CMD that checks every popped response.
// Define KEYPRT_SEQ_ERRCNT_EN to keep playing past mismatches and count all of them.
module keyprt_seq_player #(
    parameter int DEPTH          = 16,
    parameter int CNT_W          = 20,
    parameter int KEY_HOLD_CYC   = 50000,
    parameter int KEY_GAP_CYC    = 50000,
    parameter int POP_SAMPLE_CYC = 4,
    parameter int POP_HOLD_CYC   = 10000,
    parameter int POP_GAP_CYC    = 10000
) (
    input  logic               i_clk,
    input  logic               i_res,
    keyprt_seq_player_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] CMD_REL = 32'h8000_0000;
    localparam logic [31:0] CMD_POP = 32'h8000_8000;
`ifdef KEYPRT_SEQ_ERRCNT_EN
    localparam int ERR_W = 8;
`else
    localparam int ERR_W = 1;
`endif

    // A duration of N cycles loads N-1; zero behaves like one.
    localparam logic [CNT_W-1:0] LD_KEY_HOLD   = (KEY_HOLD_CYC   <= 1) ? '0 : CNT_W'(KEY_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_KEY_GAP    = (KEY_GAP_CYC    <= 1) ? '0 : CNT_W'(KEY_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_POP_SAMPLE = (POP_SAMPLE_CYC <= 1) ? '0 : CNT_W'(POP_SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_POP_HOLD   = (POP_HOLD_CYC   <= 1) ? '0 : CNT_W'(POP_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_POP_GAP    = (POP_GAP_CYC    <= 1) ? '0 : CNT_W'(POP_GAP_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_KEY_ON, S_KEY_OFF, S_POP_ON, S_POP_HOLD, S_POP_OFF, S_WAIT, S_FIN
    } state_t;

    state_t            r_state;
    logic [39:0]       r_mem [DEPTH];
    logic [31:0]       r_cmd;
    logic [CNT_W-1:0]  r_cnt;
    logic [AW-1:0]     r_step;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [AW-1:0]     r_failStep;
    logic [31:0]       r_failData;
    logic [ERR_W-1:0]  r_err;
    logic [31:0]       r_expect;

    state_t            w_nextState;
    logic [31:0]       w_nextCmd;
    logic [CNT_W-1:0]  w_nextCnt;
    logic [AW-1:0]     w_nextStep;
    logic              w_nextBusy;
    logic              w_nextDone;
    logic              w_nextPass;
    logic [AW-1:0]     w_nextFailStep;
    logic [31:0]       w_nextFailData;
    logic [ERR_W-1:0]  w_nextErr;
    logic [31:0]       w_nextExpect;
    logic              w_advance;
    logic [39:0]       w_entry;
    logic [CNT_W-1:0]  w_idleLen;
    logic              w_cntZero;

    assign w_entry   = r_mem[r_step];
    assign w_idleLen = w_entry[CNT_W-1:0];
    assign w_cntZero = (r_cnt == '0);

    // Writes land during the START cycle too, so FETCH sees freshly written data.
    always_ff @(posedge i_clk) begin
        if (!i_res && bus.prgWe && !r_busy) begin
            r_mem[bus.prgAddr] <= bus.prgWdata;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextCmd      = r_cmd;
        w_nextCnt      = r_cnt;
        w_nextStep     = r_step;
        w_nextBusy     = r_busy;
        w_nextDone     = r_done;
        w_nextPass     = r_pass;
        w_nextFailStep = r_failStep;
        w_nextFailData = r_failData;
        w_nextErr      = r_err;
        w_nextExpect   = r_expect;
        w_advance      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_nextDone     = 1'b0;
                    w_nextPass     = 1'b0;
                    w_nextFailStep = '0;
                    w_nextFailData = '0;
                    w_nextErr      = '0;
                    w_nextStep     = '0;
                    w_nextBusy     = 1'b1;
                    w_nextState    = S_FETCH;
                end
            end
            S_FETCH: begin
                case (w_entry[39:38])
                    2'b00: begin
                        w_nextCmd   = CMD_REL | {24'h0, w_entry[7:0]};
                        w_nextCnt   = LD_KEY_HOLD;
                        w_nextState = S_KEY_ON;
                    end
                    2'b01: begin
                        w_nextCmd    = CMD_POP;
                        w_nextCnt    = LD_POP_SAMPLE;
                        w_nextExpect = w_entry[31:0];
                        w_nextState  = S_POP_ON;
                    end
                    2'b10: begin
                        w_nextCmd   = CMD_REL;
                        w_nextCnt   = (w_idleLen == '0) ? '0 : w_idleLen - 1'b1;
                        w_nextState = S_WAIT;
                    end
                    default: w_nextState = S_FIN;
                endcase
            end
            S_KEY_ON: begin
                if (w_cntZero) begin
                    w_nextCmd   = CMD_REL;
                    w_nextCnt   = LD_KEY_GAP;
                    w_nextState = S_KEY_OFF;
                end else begin
                    w_nextCnt = r_cnt - 1'b1;
                end
            end
            S_KEY_OFF: begin
                if (w_cntZero) w_advance = 1'b1;
                else           w_nextCnt = r_cnt - 1'b1;
            end
            S_POP_ON: begin
                if (w_cntZero) begin
                    if (bus.keyprtRes != r_expect) begin
                        if (r_err == '0) begin
                            w_nextFailStep = r_step;
                            w_nextFailData = bus.keyprtRes;
                        end
                        if (r_err != '1) w_nextErr = r_err + 1'b1;
                    end
                    w_nextCnt   = LD_POP_HOLD;
                    w_nextState = S_POP_HOLD;
                end else begin
                    w_nextCnt = r_cnt - 1'b1;
                end
            end
            S_POP_HOLD: begin
                if (w_cntZero) begin
                    w_nextCmd   = CMD_REL;
                    w_nextCnt   = LD_POP_GAP;
                    w_nextState = S_POP_OFF;
                end else begin
                    w_nextCnt = r_cnt - 1'b1;
                end
            end
            S_POP_OFF, S_WAIT: begin
                if (w_cntZero) w_advance = 1'b1;
                else           w_nextCnt = r_cnt - 1'b1;
            end
            S_FIN: begin
                w_nextCmd   = CMD_REL;
                w_nextBusy  = 1'b0;
                w_nextDone  = 1'b1;
                w_nextPass  = (r_err == '0);
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase

        // The last entry ends playback; the script never wraps.
        if (w_advance) begin
`ifdef KEYPRT_SEQ_ERRCNT_EN
            if (r_step == AW'(DEPTH - 1)) begin
`else
            if (r_err != '0 || r_step == AW'(DEPTH - 1)) begin
`endif
                w_nextState = S_FIN;
            end else begin
                w_nextStep  = r_step + AW'(1);
                w_nextState = S_FETCH;
            end
        end

        if (bus.abort && r_busy) begin
            w_nextState = S_IDLE;
            w_nextCmd   = CMD_REL;
            w_nextBusy  = 1'b0;
            w_nextDone  = r_done;
            w_nextPass  = r_pass;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_cmd      <= '0;
            r_cnt      <= '0;
            r_step     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_failStep <= '0;
            r_failData <= '0;
            r_err      <= '0;
            r_expect   <= '0;
        end else begin
            r_cmd      <= w_nextCmd;
            r_cnt      <= w_nextCnt;
            r_step     <= w_nextStep;
            r_busy     <= w_nextBusy;
            r_done     <= w_nextDone;
            r_pass     <= w_nextPass;
            r_failStep <= w_nextFailStep;
            r_failData <= w_nextFailData;
            r_err      <= w_nextErr;
            r_expect   <= w_nextExpect;
        end
    end

    assign bus.keyprtCmd = r_cmd;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.failStep  = r_failStep;
    assign bus.failData  = r_failData;
    assign bus.errCount  = 8'(r_err);
endmodule

// File: tb/tb_keyprt_seq_player.sv
// Randomized self-checking bench for keyprt_seq_player; expected command traces and
// status come from a script-level model built before each playback.
module tb_keyprt_seq_player;
    localparam int DEPTH      = 16;
    localparam int AW         = $clog2(DEPTH);
    localparam int CNT_W      = 12;
    localparam int KEY_HOLD   = 8;
    localparam int KEY_GAP    = 8;
    localparam int POP_SAMPLE = 4;
    localparam int POP_HOLD   = 3;
    localparam int POP_GAP    = 3;
    localparam logic [31:0] CMD_REL = 32'h8000_0000;
    localparam logic [31:0] CMD_POP = 32'h8000_8000;
`ifdef KEYPRT_SEQ_ERRCNT_EN
    localparam int ERR_CAP      = 255;
    localparam bit STOP_ON_FAIL = 1'b0;
`else
    localparam int ERR_CAP      = 1;
    localparam bit STOP_ON_FAIL = 1'b1;
`endif

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    keyprt_seq_player_if #(.DEPTH(DEPTH)) bus ();

    keyprt_seq_player #(
        .DEPTH(DEPTH), .CNT_W(CNT_W),
        .KEY_HOLD_CYC(KEY_HOLD), .KEY_GAP_CYC(KEY_GAP),
        .POP_SAMPLE_CYC(POP_SAMPLE), .POP_HOLD_CYC(POP_HOLD), .POP_GAP_CYC(POP_GAP)
    ) dut (
        .i_clk(clk),
        .i_res(res),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [39:0] script  [DEPTH];
    logic [31:0] respTab [DEPTH];
    logic [31:0] expCmdQ [$];
    logic        expBusyQ [$];
    logic [31:0] resQ [$];
    logic [31:0] lastCmd;
    int          mErr;
    logic [AW-1:0] mFailStep;
    logic [31:0] mFailData;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void pushCyc(input logic [31:0] c, input logic b, input logic [31:0] r);
        expCmdQ.push_back(c);
        expBusyQ.push_back(b);
        resQ.push_back(r);
    endfunction

    // Per-cycle expectations from the START cycle through the FIN cycle.
    function automatic void buildModel();
        logic [31:0] cur;
        logic [31:0] resp;
        logic [39:0] e;
        int step;
        int n;
        bit finished;
        expCmdQ.delete();
        expBusyQ.delete();
        resQ.delete();
        mErr = 0;
        mFailStep = '0;
        mFailData = '0;
        cur = lastCmd;
        pushCyc(cur, 1'b0, $urandom());
        step = 0;
        finished = 1'b0;
        while (!finished) begin
            pushCyc(cur, 1'b1, $urandom());
            e = script[step];
            case (e[39:38])
                2'b00: begin
                    cur = CMD_REL | {24'h0, e[7:0]};
                    repeat (KEY_HOLD) pushCyc(cur, 1'b1, $urandom());
                    cur = CMD_REL;
                    repeat (KEY_GAP) pushCyc(cur, 1'b1, $urandom());
                end
                2'b01: begin
                    resp = respTab[step];
                    cur = CMD_POP;
                    for (int k = 0; k < POP_SAMPLE; k++)
                        pushCyc(cur, 1'b1, (k == POP_SAMPLE - 1) ? resp : ~resp);
                    repeat (POP_HOLD) pushCyc(cur, 1'b1, ~resp);
                    cur = CMD_REL;
                    repeat (POP_GAP) pushCyc(cur, 1'b1, $urandom());
                    if (resp != e[31:0]) begin
                        if (mErr == 0) begin
                            mFailStep = AW'(step);
                            mFailData = resp;
                        end
                        if (mErr < ERR_CAP) mErr++;
                    end
                end
                2'b10: begin
                    n = int'(e[CNT_W-1:0]);
                    if (n == 0) n = 1;
                    cur = CMD_REL;
                    repeat (n) pushCyc(cur, 1'b1, $urandom());
                end
                default: finished = 1'b1;
            endcase
            if (!finished) begin
                if ((STOP_ON_FAIL && mErr != 0) || step == DEPTH - 1) finished = 1'b1;
                else step++;
            end
        end
        pushCyc(cur, 1'b1, $urandom());
    endfunction

    function automatic logic [39:0] randEntry(input int i, input bit allowMiss);
        logic [31:0] v;
        logic [39:0] e;
        v = $urandom();
        case ($urandom_range(0, 2))
            0:       e = {2'b00, 30'h0, v[7:0]};
            1:       e = {2'b01, 6'h0, v};
            default: e = {2'b10, 38'($urandom_range(0, 5))};
        endcase
        respTab[i] = e[31:0];
        if (allowMiss && $urandom_range(0, 3) == 0)
            respTab[i] = e[31:0] ^ (32'h1 << $urandom_range(0, 31));
        return e;
    endfunction

    task automatic loadScript();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bus.prgWe    = 1'b1;
            bus.prgAddr  = AW'(i);
            bus.prgWdata = script[i];
        end
        @(negedge clk);
        bus.prgWe = 1'b0;
    endtask

    task automatic fillEnd();
        for (int i = 0; i < DEPTH; i++) begin
            script[i]  = {2'b11, 38'h0};
            respTab[i] = 32'h0;
        end
    endtask

    task automatic applyStimulus(input string name, input bit disturb,
                                 input bit sameWrite, input logic [39:0] newEntry0);
        if (sameWrite) script[0] = newEntry0;
        buildModel();
        for (int j = 0; j < expCmdQ.size(); j++) begin
            @(negedge clk);
            checkOutput($sformatf("%s.cmd@%0d", name, j), bus.keyprtCmd, expCmdQ[j]);
            checkOutput($sformatf("%s.busy@%0d", name, j), 32'(bus.busy), 32'(expBusyQ[j]));
            if (j == 1) checkOutput($sformatf("%s.doneClr", name), 32'(bus.done), 32'h0);
            bus.start     = (j == 0);
            bus.prgWe     = 1'b0;
            bus.keyprtRes = resQ[j];
            if (sameWrite && j == 0) begin
                bus.prgWe    = 1'b1;
                bus.prgAddr  = '0;
                bus.prgWdata = newEntry0;
            end
            if (disturb && j == 6) begin
                bus.start    = 1'b1;
                bus.prgWe    = 1'b1;
                bus.prgAddr  = AW'(DEPTH - 1);
                bus.prgWdata = {2'b11, 38'h0};
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.prgWe = 1'b0;
        checkOutput($sformatf("%s.endCmd", name), bus.keyprtCmd, CMD_REL);
        checkOutput($sformatf("%s.endBusy", name), 32'(bus.busy), 32'h0);
        checkOutput($sformatf("%s.done", name), 32'(bus.done), 32'h1);
        checkOutput($sformatf("%s.pass", name), 32'(bus.pass), 32'(mErr == 0));
        checkOutput($sformatf("%s.errCount", name), 32'(bus.errCount), 32'(mErr));
        checkOutput($sformatf("%s.failStep", name), 32'(bus.failStep), 32'(mFailStep));
        checkOutput($sformatf("%s.failData", name), bus.failData, mFailData);
        lastCmd = CMD_REL;
    endtask

    initial begin
        int endPos;
        logic [39:0] e0;
        res           = 1'b1;
        bus.prgWe     = 1'b0;
        bus.prgAddr   = '0;
        bus.prgWdata  = '0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.keyprtRes = '0;
        lastCmd       = 32'h0;
        repeat (3) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        checkOutput("rst.cmd", bus.keyprtCmd, 32'h0);
        checkOutput("rst.busy", 32'(bus.busy), 32'h0);
        checkOutput("rst.done", 32'(bus.done), 32'h0);
        checkOutput("rst.pass", 32'(bus.pass), 32'h0);
        checkOutput("rst.errCount", 32'(bus.errCount), 32'h0);
        checkOutput("rst.failData", bus.failData, 32'h0);

        fillEnd();
        script[0] = {2'b00, 30'h0, 8'h9b};
        loadScript();
        applyStimulus("key9b", 1'b0, 1'b0, 40'h0);

        fillEnd();
        script[0] = {2'b01, 6'h0, 32'h8000_2c01};
        respTab[0] = 32'h8000_2c01;
        loadScript();
        applyStimulus("popOk", 1'b0, 1'b0, 40'h0);

        fillEnd();
        script[0] = {2'b01, 6'h0, 32'h8000_3001};
        script[1] = {2'b01, 6'h0, 32'h8000_0001};
        respTab[0] = 32'h8000_3001;
        respTab[1] = 32'h8000_0c01;
        loadScript();
        applyStimulus("popMiss", 1'b0, 1'b0, 40'h0);

        for (int i = 0; i < DEPTH; i++) script[i] = randEntry(i, 1'b0);
        loadScript();
        applyStimulus("full16", 1'b1, 1'b0, 40'h0);

        fillEnd();
        script[0] = {2'b00, 30'h0, 8'h8e};
        loadScript();
        @(negedge clk);
        bus.start = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (j == 4) begin
                checkOutput("abort.keyOn", bus.keyprtCmd, 32'h8000_008e);
                bus.abort = 1'b1;
            end
        end
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("abort.cmd", bus.keyprtCmd, CMD_REL);
        checkOutput("abort.busy", 32'(bus.busy), 32'h0);
        checkOutput("abort.done", 32'(bus.done), 32'h0);
        checkOutput("abort.pass", 32'(bus.pass), 32'h0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("abortStart.busy@%0d", j), 32'(bus.busy), 32'h0);
            checkOutput($sformatf("abortStart.cmd@%0d", j), bus.keyprtCmd, CMD_REL);
            @(negedge clk);
        end
        lastCmd = CMD_REL;
        applyStimulus("abortReplay", 1'b0, 1'b0, 40'h0);

        for (int t = 0; t < 8; t++) begin
            fillEnd();
            endPos = $urandom_range(1, DEPTH);
            for (int i = 0; i < endPos && i < DEPTH; i++) script[i] = randEntry(i, 1'b1);
            loadScript();
            if (t == 0) begin
                e0 = randEntry(0, 1'b1);
                applyStimulus($sformatf("rnd%0d", t), 1'b0, 1'b1, e0);
            end else begin
                applyStimulus($sformatf("rnd%0d", t), 1'b0, 1'b0, 40'h0);
            end
        end

        fillEnd();
        script[0] = {2'b01, 6'h0, 32'h1234_5678};
        loadScript();
        @(negedge clk);
        bus.start = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.keyprtRes = (j == 5) ? 32'h1234_5679 : 32'h0;
        end
        checkOutput("rstMid.cmdHold", bus.keyprtCmd, CMD_POP);
        checkOutput("rstMid.errBefore", 32'(bus.errCount), 32'h1);
        checkOutput("rstMid.dataBefore", bus.failData, 32'h1234_5679);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        checkOutput("rstMid.cmd", bus.keyprtCmd, 32'h0);
        checkOutput("rstMid.busy", 32'(bus.busy), 32'h0);
        checkOutput("rstMid.done", 32'(bus.done), 32'h0);
        checkOutput("rstMid.pass", 32'(bus.pass), 32'h0);
        checkOutput("rstMid.errCount", 32'(bus.errCount), 32'h0);
        checkOutput("rstMid.failStep", 32'(bus.failStep), 32'h0);
        checkOutput("rstMid.failData", bus.failData, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
